// File: rtl/data_sram_responder_if.sv
// Data SRAM port bundle between the core (master) and data_sram_responder (slave).
interface data_sram_responder_if;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word RAM plus an MMIO window (LED, switch, optional timer/IRQ).
// Optional timer block enabled by defining DATA_SRAM_RESP_TIMER_EN.
module data_sram_responder #(
   parameter int unsigned ADDR_W    = 12,
   parameter logic [31:0] MMIO_BASE = 32'hBFAF_0000,
   parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
   input  logic                 clk,
   input  logic                 rst,
   data_sram_responder_if.slave bus,
   input  logic [7:0]           switch,
   output logic [15:0]          led,
   output logic                 timer_irq
);
   localparam int unsigned DEPTH   = 1 << ADDR_W;
   localparam logic [13:0] OFF_LED = 14'h0;
   localparam logic [13:0] OFF_SW  = 14'h1;
`ifdef DATA_SRAM_RESP_TIMER_EN
   localparam logic [13:0] OFF_TMR = 14'h2;
   localparam logic [13:0] OFF_CMP = 14'h3;
   localparam logic [13:0] OFF_IRQ = 14'h4;
`endif

   // Byte-lane merge shared by RAM and every RW register.
   function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  be);
      logic [31:0] res;
      res = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   logic [31:0]       mem [DEPTH];
   logic [31:0]       rdata_q, rdata_d;
   logic [15:0]       led_q, led_d;
   logic [7:0]        sw_meta_q, sw_sync_q;

   logic              write_c, is_mmio_c;
   logic [ADDR_W-1:0] idx_c;
   logic [13:0]       woff_c;
   logic [31:0]       ram_merged_c, mmio_cur_c, mmio_merged_c;

`ifdef DATA_SRAM_RESP_TIMER_EN
   logic [31:0]       timer_q, timer_d, cmp_q, cmp_d;
   logic              irq_q, irq_d, timer_irq_q, irq_clr_c;
`endif

   assign write_c       = bus.data_sram_en & (|bus.data_sram_wen);
   assign is_mmio_c     = (bus.data_sram_addr & MMIO_MASK) == MMIO_BASE;
   assign idx_c         = bus.data_sram_addr[ADDR_W+1:2];
   assign woff_c        = bus.data_sram_addr[15:2];
   assign ram_merged_c  = merge_lanes(mem[idx_c], bus.data_sram_wdata, bus.data_sram_wen);
   assign mmio_merged_c = merge_lanes(mmio_cur_c, bus.data_sram_wdata, bus.data_sram_wen);

   // RAM array is never reset; accesses during reset are dropped.
   always_ff @(posedge clk) begin
      if (rst && write_c && !is_mmio_c) mem[idx_c] <= ram_merged_c;
   end

   // Current value of the addressed MMIO register.
   always_comb begin
      mmio_cur_c = '0;
      case (woff_c)
         OFF_LED: mmio_cur_c = {16'h0, led_q};
         OFF_SW:  mmio_cur_c = {24'h0, sw_sync_q};
`ifdef DATA_SRAM_RESP_TIMER_EN
         OFF_TMR: mmio_cur_c = timer_q;
         OFF_CMP: mmio_cur_c = cmp_q;
         OFF_IRQ: mmio_cur_c = {31'h0, irq_q};
`endif
         default: mmio_cur_c = '0;
      endcase
   end

`ifdef DATA_SRAM_RESP_TIMER_EN
   assign irq_clr_c = write_c & is_mmio_c & (woff_c == OFF_IRQ)
                    & bus.data_sram_wen[0] & bus.data_sram_wdata[0];
`endif

   // Next-state and write-first read data.
   always_comb begin
      rdata_d = rdata_q;
      led_d   = led_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
      timer_d = timer_q + 32'd1;
      cmp_d   = cmp_q;
      irq_d   = (timer_q == cmp_q) | (irq_q & ~irq_clr_c);
`endif
      if (bus.data_sram_en) begin
         if (!is_mmio_c) begin
            rdata_d = ram_merged_c;
         end else begin
            rdata_d = mmio_merged_c;
            case (woff_c)
               OFF_LED: begin
                  if (write_c) led_d = mmio_merged_c[15:0];
                  rdata_d = {16'h0, mmio_merged_c[15:0]};
               end
               OFF_SW:  rdata_d = mmio_cur_c;
`ifdef DATA_SRAM_RESP_TIMER_EN
               OFF_TMR: if (write_c) timer_d = mmio_merged_c;
               OFF_CMP: if (write_c) cmp_d = mmio_merged_c;
               OFF_IRQ: rdata_d = write_c ? {31'h0, irq_d} : mmio_cur_c;
`endif
               default: rdata_d = '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_q     <= '0;
         led_q       <= '0;
         sw_meta_q   <= '0;
         sw_sync_q   <= '0;
`ifdef DATA_SRAM_RESP_TIMER_EN
         timer_q     <= '0;
         cmp_q       <= 32'hFFFF_FFFF;
         irq_q       <= 1'b0;
         timer_irq_q <= 1'b0;
`endif
      end else begin
         rdata_q     <= rdata_d;
         led_q       <= led_d;
         sw_meta_q   <= switch;
         sw_sync_q   <= sw_meta_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
         timer_q     <= timer_d;
         cmp_q       <= cmp_d;
         irq_q       <= irq_d;
         timer_irq_q <= irq_q;
`endif
      end
   end

   assign bus.data_sram_rdata = rdata_q;
   assign led                 = led_q;
`ifdef DATA_SRAM_RESP_TIMER_EN
   assign timer_irq           = timer_irq_q;
`else
   assign timer_irq           = 1'b0;
`endif
endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: driver queues expected rdata, monitor checks it.
module tb_data_sram_responder;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [7:0]  switch_r;
   logic [15:0] led_w;
   logic        timer_irq_w;

   data_sram_responder_if bus ();

   data_sram_responder dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .switch    (switch_r),
      .led       (led_w),
      .timer_irq (timer_irq_w)
   );

   always #5 clk = ~clk;

   string       name_q[$];
   logic [31:0] val_q[$];
   int          n_pass  = 0;
   int          n_total = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   // One-cycle access; expected rdata is queued for the monitor.
   task automatic access(input string name, input logic [31:0] addr, input logic [3:0] wen,
                         input logic [31:0] wdata, input logic [31:0] exp);
      name_q.push_back(name);
      val_q.push_back(exp);
      bus.data_sram_en    = 1'b1;
      bus.data_sram_wen   = wen;
      bus.data_sram_addr  = addr;
      bus.data_sram_wdata = wdata;
      @(posedge clk);
      #1;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: an access taken at a rising edge is compared at the following falling edge.
   initial begin : monitor
      logic        fire;
      string       nm;
      logic [31:0] ev;
      forever begin
         @(posedge clk);
         fire = bus.data_sram_en & rst;
         @(negedge clk);
         if (fire) begin
            if (val_q.size() == 0) begin
               n_total++;
               $display("FAIL unexpected_output: got 0x%08h, expected no access", bus.data_sram_rdata);
            end else begin
               nm = name_q.pop_front();
               ev = val_q.pop_front();
               check(nm, bus.data_sram_rdata, ev);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic irq_seen;
      bus.data_sram_en    = 1'b0;
      bus.data_sram_wen   = 4'h0;
      bus.data_sram_addr  = '0;
      bus.data_sram_wdata = '0;
      switch_r            = 8'h00;
      rst                 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rdata", bus.data_sram_rdata, 32'h0);
      check("reset_led", {16'h0, led_w}, 32'h0);
      check("reset_timer_irq", {31'h0, timer_irq_w}, 32'h0);
      rst = 1'b1;
      idle(1);

`ifdef DATA_SRAM_RESP_TIMER_EN
      access("reset_cmp_read", 32'hBFAF_000C, 4'h0, 32'h0, 32'hFFFF_FFFF);
`else
      access("unmapped_cmp_read", 32'hBFAF_000C, 4'h0, 32'h0, 32'h0);
`endif

      // RAM lanes, aliasing and write-first
      access("ram_wr_full",    32'h0000_0100, 4'hF,    32'h1122_3344, 32'h1122_3344);
      access("ram_wr_lanes",   32'h0000_0100, 4'b0101, 32'hAABB_CCDD, 32'h11BB_33DD);
      access("ram_rd",         32'h0000_0100, 4'h0,    32'h0,         32'h11BB_33DD);
      access("ram_rd_alias",   32'h0000_4100, 4'h0,    32'h0,         32'h11BB_33DD);
      access("ram_rd_lowbits", 32'h0000_0103, 4'h0,    32'h0,         32'h11BB_33DD);
      access("ram_wr_first",   32'h0000_0200, 4'hF,    32'hDEAD_BEEF, 32'hDEAD_BEEF);
      idle(1);
      check("rdata_hold_1", bus.data_sram_rdata, 32'hDEAD_BEEF);
      idle(1);
      check("rdata_hold_2", bus.data_sram_rdata, 32'hDEAD_BEEF);
      access("near_mmio_wr",   32'hBFAE_0000, 4'hF,    32'h1234_5678, 32'h1234_5678);
      access("near_mmio_rd",   32'h0000_0000, 4'h0,    32'h0,         32'h1234_5678);

      // MMIO LED / SWITCH / unmapped
      access("led_wr", 32'hBFAF_0000, 4'hF, 32'h0000_A5A5, 32'h0000_A5A5);
      check("led_out", {16'h0, led_w}, 32'h0000_A5A5);
      access("led_wr_lane1", 32'hBFAF_0000, 4'b0010, 32'h0000_3C00, 32'h0000_3CA5);
      access("led_wr_upper", 32'hBFAF_0000, 4'b1100, 32'hFFFF_0000, 32'h0000_3CA5);
      access("led_rd_lowbits", 32'hBFAF_0001, 4'h0, 32'h0, 32'h0000_3CA5);
      check("led_out_2", {16'h0, led_w}, 32'h0000_3CA5);
      switch_r = 8'h3C;
      idle(3);
      access("switch_rd", 32'hBFAF_0004, 4'h0, 32'h0, 32'h0000_003C);
      access("switch_wr_ignored", 32'hBFAF_0004, 4'hF, 32'h0000_00FF, 32'h0000_003C);
      access("unmapped_rd", 32'hBFAF_0040, 4'h0, 32'h0, 32'h0);
      access("unmapped_wr", 32'hBFAF_0040, 4'hF, 32'h5555_5555, 32'h0);

`ifdef DATA_SRAM_RESP_TIMER_EN
      // Timer load lands at edge E0; the match on TIMER==10 sets IRQ at E11, timer_irq at E12.
      access("timer_load_0", 32'hBFAF_0008, 4'hF, 32'h0, 32'h0);
      access("cmp_wr_10",    32'hBFAF_000C, 4'hF, 32'd10, 32'd10);
      idle(10);
      check("timer_irq_lag", {31'h0, timer_irq_w}, 32'h0);
      idle(1);
      check("timer_irq_rise", {31'h0, timer_irq_w}, 32'h1);
      access("irq_rd_set",       32'hBFAF_0010, 4'h0,    32'h0,   32'h1);
      access("irq_w1c_nomatch",  32'hBFAF_0010, 4'b0001, 32'h1,   32'h0);
      access("timer_load_100",   32'hBFAF_0008, 4'hF,    32'd100, 32'd100);
      access("cmp_wr_102",       32'hBFAF_000C, 4'hF,    32'd102, 32'd102);
      idle(1);
      access("irq_w1c_set_wins", 32'hBFAF_0010, 4'b0001, 32'h1,   32'h1);
      access("irq_w1c_clear",    32'hBFAF_0010, 4'b0001, 32'h1,   32'h0);
      access("timer_rd",         32'hBFAF_0008, 4'h0,    32'h0,   32'd104);
      access("timer_load_max",   32'hBFAF_0008, 4'hF,    32'hFFFF_FFFF, 32'hFFFF_FFFF);
      access("timer_rd_max",     32'hBFAF_0008, 4'h0,    32'h0,   32'hFFFF_FFFF);
      access("timer_rd_wrap",    32'hBFAF_0008, 4'h0,    32'h0,   32'h0);
`else
      access("unmapped_cmp_wr", 32'hBFAF_000C, 4'hF, 32'd5, 32'h0);
      access("unmapped_cmp_rd", 32'hBFAF_000C, 4'h0, 32'h0, 32'h0);
      access("unmapped_tmr_rd", 32'hBFAF_0008, 4'h0, 32'h0, 32'h0);
      irq_seen = 1'b0;
      repeat (1000) begin
         @(negedge clk);
         if (timer_irq_w !== 1'b0) irq_seen = 1'b1;
      end
      #1;
      check("timer_irq_tied_low", {31'h0, irq_seen}, 32'h0);
`endif

      idle(2);
      check("scoreboard_drain", 32'(val_q.size()), 32'h0);

      // Asynchronous reset mid-cycle clears registered outputs immediately.
      #2;
      rst = 1'b0;
      #1;
      check("async_reset_rdata", bus.data_sram_rdata, 32'h0);
      check("async_reset_led", {16'h0, led_w}, 32'h0);
      check("async_reset_irq", {31'h0, timer_irq_w}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
